// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, requester IDs and the
// latched slave command.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_cmd_t;

    localparam logic [3:0] IF_BYTE_EN = 4'hF;

    // On a tie the port that did not win last time gets the bus.
    function automatic port_id_e pick_winner(input logic     if_req,
                                             input logic     dm_req,
                                             input port_id_e last_grant);
        if (if_req && dm_req) begin
            return (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
        end
        return dm_req ? PORT_DM : PORT_IF;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the arbiter's requester and slave-bus signals. The master view is
// the arbiter itself; the slave view is the requesters plus the memory device.
interface mem_bus_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic [31:0] sl_addr;
    logic [31:0] sl_wdata;
    logic [3:0]  sl_be;
    logic        sl_oe_n;
    logic        sl_we_n;
    logic [31:0] sl_rdata;

    logic        busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, sl_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output sl_addr, sl_wdata, sl_be, sl_oe_n, sl_we_n, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, sl_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  sl_addr, sl_wdata, sl_be, sl_oe_n, sl_we_n, busy
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction read / data read-write) arbiter onto one asynchronous
// SRAM-style slave with setup, WAIT_CYCLES strobe cycles and a completion cycle.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,

    output logic [31:0] sl_addr,
    output logic [31:0] sl_wdata,
    output logic [3:0]  sl_be,
    output logic        sl_oe_n,
    output logic        sl_we_n,
    input  logic [31:0] sl_rdata,

    output logic        busy
);

    localparam logic [3:0] ACCESS_LOAD = 4'(WAIT_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    port_id_e    last_grant_q, last_grant_d;
    port_id_e    gnt_q, gnt_d;
    bus_cmd_t    cmd_q, cmd_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    port_id_e    winner;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cmd_d        = cmd_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        winner       = pick_winner(if_req, dm_req, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    gnt_d        = winner;
                    last_grant_d = winner;
                    if (winner == PORT_DM) begin
                        cmd_d = '{addr: dm_addr, wdata: dm_wdata, be: dm_be, we: dm_we};
                    end else begin
                        cmd_d = '{addr: if_addr, wdata: '0, be: IF_BYTE_EN, we: 1'b0};
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = ACCESS_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Read data is taken while the read strobe is still low.
                    if (!cmd_q.we) begin
                        if (gnt_q == PORT_DM) begin
                            dm_rdata_d = sl_rdata;
                        end else begin
                            if_rdata_d = sl_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_IF;
            gnt_q        <= PORT_IF;
            cmd_q        <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cmd_q        <= cmd_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Strobes and acks decode the state flops, so an async reset drops them
    // at once and the two strobes can never overlap.
    assign sl_oe_n  = !((state_q == ST_ACCESS) && !cmd_q.we);
    assign sl_we_n  = !((state_q == ST_ACCESS) &&  cmd_q.we);
    assign if_ack   = (state_q == ST_DONE) && (gnt_q == PORT_IF);
    assign dm_ack   = (state_q == ST_DONE) && (gnt_q == PORT_DM);
    assign busy     = (state_q != ST_IDLE);

    assign sl_addr  = cmd_q.addr;
    assign sl_wdata = cmd_q.wdata;
    assign sl_be    = cmd_q.be;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus hand sequences,
// with a queue-based scoreboard checked whenever an ack appears.
module tb_mem_bus_arbiter;
    import bus_pkg::*;

    localparam int W = 2;

    typedef struct {
        port_id_e    port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .if_addr  (bus.if_addr),
        .if_rdata (bus.if_rdata),
        .if_ack   (bus.if_ack),
        .dm_req   (bus.dm_req),
        .dm_we    (bus.dm_we),
        .dm_addr  (bus.dm_addr),
        .dm_wdata (bus.dm_wdata),
        .dm_be    (bus.dm_be),
        .dm_rdata (bus.dm_rdata),
        .dm_ack   (bus.dm_ack),
        .sl_addr  (bus.sl_addr),
        .sl_wdata (bus.sl_wdata),
        .sl_be    (bus.sl_be),
        .sl_oe_n  (bus.sl_oe_n),
        .sl_we_n  (bus.sl_we_n),
        .sl_rdata (bus.sl_rdata),
        .busy     (bus.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave memory model: data only valid while the read strobe is low.
    function automatic logic [31:0] slave_model(input logic [31:0] addr);
        if (addr == 32'hBFD0_03F8) return 32'h0000_0041;
        return {addr[15:0] ^ 16'hC3C3, addr[31:16]};
    endfunction

    always_comb bus.sl_rdata = bus.sl_oe_n ? 32'hDEAD_0000 : slave_model(bus.sl_addr);

    // Scoreboard monitor.
    vec_t        sb_q[$];
    int          oe_cyc = 0;
    int          we_cyc = 0;
    int          overlap = 0;
    int          ack_total = 0;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;

    always @(negedge clk) begin
        vec_t     e;
        port_id_e ack_port;
        if (rst) begin
            oe_cyc = 0;
            we_cyc = 0;
        end else begin
            if (!bus.sl_oe_n || !bus.sl_we_n) begin
                if (oe_cyc == 0 && we_cyc == 0) begin
                    snap_addr  = bus.sl_addr;
                    snap_wdata = bus.sl_wdata;
                    snap_be    = bus.sl_be;
                end
                if (!bus.sl_oe_n) oe_cyc++;
                if (!bus.sl_we_n) we_cyc++;
                if (!bus.sl_oe_n && !bus.sl_we_n) overlap++;
            end
            if (bus.if_ack && bus.dm_ack) overlap++;
            if (bus.if_ack || bus.dm_ack) begin
                ack_total++;
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    ack_port = bus.dm_ack ? PORT_DM : PORT_IF;
                    check("ack_port", 32'(ack_port), 32'(e.port));
                    check("strobe_cycles", e.we ? we_cyc : oe_cyc, W);
                    check("other_strobe_cycles", e.we ? oe_cyc : we_cyc, 0);
                    check("sl_addr", snap_addr, e.addr);
                    check("sl_be", 32'(snap_be), 32'(e.exp_be));
                    if (e.we) begin
                        check("sl_wdata", snap_wdata, e.wdata);
                    end else if (e.port == PORT_DM) begin
                        check("dm_rdata", bus.dm_rdata, e.exp_rdata);
                    end else begin
                        check("if_rdata", bus.if_rdata, e.exp_rdata);
                    end
                end
                oe_cyc = 0;
                we_cyc = 0;
            end
        end
    end

    task automatic drive_req(input vec_t v);
        if (v.port == PORT_DM) begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = v.we;
            bus.dm_addr  = v.addr;
            bus.dm_wdata = v.wdata;
            bus.dm_be    = v.be;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
    endtask

    task automatic drop_req(input port_id_e p);
        if (p == PORT_DM) bus.dm_req = 1'b0;
        else              bus.if_req = 1'b0;
    endtask

    task automatic wait_any_ack(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack) begin
                cycles = i;
                break;
            end
        end
    endtask

    vec_t        vecs[6];
    vec_t        v;
    int          cyc;
    int          acks_before;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{port: PORT_DM, we: 1'b0, addr: 32'hBFD0_03F8, wdata: 32'h0, be: 4'hF,
                    exp_be: 4'hF, exp_rdata: 32'h0000_0041};
        vecs[1] = '{port: PORT_DM, we: 1'b1, addr: 32'h8040_0000, wdata: 32'hDEAD_BEEF, be: 4'b0011,
                    exp_be: 4'b0011, exp_rdata: 32'h0};
        vecs[2] = '{port: PORT_IF, we: 1'b0, addr: 32'h0000_1000, wdata: 32'h0, be: 4'h0,
                    exp_be: 4'hF, exp_rdata: slave_model(32'h0000_1000)};
        vecs[3] = '{port: PORT_DM, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, be: 4'b0110,
                    exp_be: 4'b0110, exp_rdata: slave_model(32'h0000_0010)};
        vecs[4] = '{port: PORT_IF, we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, be: 4'h0,
                    exp_be: 4'hF, exp_rdata: slave_model(32'hFFFF_FFFC)};
        vecs[5] = '{port: PORT_DM, we: 1'b1, addr: 32'h1234_5678, wdata: 32'hA5A5_5A5A, be: 4'b1100,
                    exp_be: 4'b1100, exp_rdata: 32'h0};

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_sl_oe_n", 32'(bus.sl_oe_n), 32'd1);
        check("rst_sl_we_n", 32'(bus.sl_we_n), 32'd1);
        check("rst_sl_addr", bus.sl_addr, 32'h0);
        check("rst_sl_wdata", bus.sl_wdata, 32'h0);
        check("rst_sl_be", 32'(bus.sl_be), 32'h0);
        check("rst_if_ack", 32'(bus.if_ack), 32'd0);
        check("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i]);
            sb_q.push_back(vecs[i]);
            wait_any_ack(cyc);
            drop_req(vecs[i].port);
            check("latency", cyc, W + 2);
            if (!vecs[i].we) begin
                if (vecs[i].port == PORT_DM) exp_dm_rdata = vecs[i].exp_rdata;
                else                         exp_if_rdata = vecs[i].exp_rdata;
            end
            @(negedge clk);
            check("if_rdata_hold", bus.if_rdata, exp_if_rdata);
            check("dm_rdata_hold", bus.dm_rdata, exp_dm_rdata);
            check("sl_addr_hold", bus.sl_addr, vecs[i].addr);
            check("busy_idle", 32'(bus.busy), 32'd0);
        end

        // Instruction request pulsed for one cycle, address scrambled afterwards.
        v = '{port: PORT_IF, we: 1'b0, addr: 32'h0000_2000, wdata: 32'h0, be: 4'h0,
              exp_be: 4'hF, exp_rdata: slave_model(32'h0000_2000)};
        drive_req(v);
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        bus.if_req  = 1'b0;
        bus.if_addr = 32'hFFFF_0000;
        wait_any_ack(cyc);
        check("pulse_latency", cyc + 1, W + 2);
        exp_if_rdata = v.exp_rdata;
        @(negedge clk);
        check("pulse_if_rdata", bus.if_rdata, exp_if_rdata);
        check("pulse_dm_rdata_hold", bus.dm_rdata, exp_dm_rdata);

        // Both ports held from reset: grants alternate dm, if, dm, if.
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_3000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_4000; bus.dm_be = 4'h5;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                v = '{port: PORT_DM, we: 1'b0, addr: 32'h0000_4000, wdata: 32'h0, be: 4'h5,
                      exp_be: 4'h5, exp_rdata: slave_model(32'h0000_4000)};
            else
                v = '{port: PORT_IF, we: 1'b0, addr: 32'h0000_3000, wdata: 32'h0, be: 4'h0,
                      exp_be: 4'hF, exp_rdata: slave_model(32'h0000_3000)};
            sb_q.push_back(v);
        end
        repeat (2) @(negedge clk);
        check("rst2_if_rdata", bus.if_rdata, 32'h0);
        check("rst2_dm_rdata", bus.dm_rdata, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(cyc);
            check("alt_gap", cyc, (k == 0) ? W + 2 : W + 3);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        exp_if_rdata = slave_model(32'h0000_3000);
        exp_dm_rdata = slave_model(32'h0000_4000);
        @(negedge clk);
        check("alt_if_rdata", bus.if_rdata, exp_if_rdata);
        check("alt_dm_rdata", bus.dm_rdata, exp_dm_rdata);
        check("alt_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a write access.
        v = '{port: PORT_DM, we: 1'b1, addr: 32'h8040_0010, wdata: 32'h1122_3344, be: 4'hF,
              exp_be: 4'hF, exp_rdata: 32'h0};
        drive_req(v);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_we_n_low", 32'(bus.sl_we_n), 32'd0);
        acks_before = ack_total;
        #2 rst = 1'b1;
        #1;
        check("abort_we_n_async", 32'(bus.sl_we_n), 32'd1);
        check("abort_oe_n_async", 32'(bus.sl_oe_n), 32'd1);
        check("abort_busy_async", 32'(bus.busy), 32'd0);
        check("abort_sl_addr", bus.sl_addr, 32'h0);
        drop_req(PORT_DM);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("abort_no_ack", ack_total, acks_before);
        check("abort_busy_after", 32'(bus.busy), 32'd0);

        check("no_overlap", overlap, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of strobe-active cycles per slave access (legal range 1..15).
REQ-002 SHALL have ports, clock and reset first:
 - clk  in  1  system clock
 - rst  in  1  reset, asynchronous, active-high
 - if_req  in  1  instruction-port read request, level
 - if_addr  in  32  instruction-port byte address
 - if_rdata  out  32  instruction-port read data
 - if_ack  out  1  instruction-port completion pulse
 - dm_req  in  1  data-port request, level
 - dm_we  in  1  data-port write (1) / read (0)
 - dm_addr  in  32  data-port byte address
 - dm_wdata  in  32  data-port write data
 - dm_be  in  4  data-port byte enables
 - dm_rdata  out  32  data-port read data
 - dm_ack  out  1  data-port completion pulse
 - sl_addr  out  32  shared slave address
 - sl_wdata  out  32  shared slave write data
 - sl_be  out  4  shared slave byte enables
 - sl_oe_n  out  1  slave read strobe, active-low
 - sl_we_n  out  1  slave write strobe, active-low
 - sl_rdata  in  32  slave read data
 - busy  out  1  high whenever state is not IDLE

Function
REQ-003 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-004 IDLE: if any request is pending, SHALL latch the winner's addr/we/wdata/be into sl_* outputs and go to SETUP; otherwise stay in IDLE.
REQ-005 Arbitration: single requester wins; if both pending, SHALL grant the port not granted last (last_grant flag); the flag updates on each grant.
REQ-006 SETUP: exactly 1 cycle, sl_oe_n=sl_we_n=1, sl_addr/sl_wdata/sl_be stable.
REQ-007 ACCESS: exactly WAIT_CYCLES cycles via a 4-bit down-counter; read asserts sl_oe_n=0 only, write asserts sl_we_n=0 only.
REQ-008 On the last ACCESS cycle of a read, SHALL register sl_rdata into the granted port's rdata register.
REQ-009 DONE: strobes high, 1-cycle ack pulse to the granted port only, then IDLE; sl_addr/sl_wdata/sl_be hold until the next grant.
REQ-010 Latency: request sampled in IDLE at edge N -> ack high during cycle N+2+WAIT_CYCLES; back-to-back transactions separated by 1 IDLE cycle.
REQ-011 Instruction port SHALL be read-only; sl_be=4'hF for instruction grants.
REQ-012 Requesters hold req and fields until ack; req dropping mid-transaction SHALL NOT abort it, ack is still issued.
REQ-013 sl_oe_n and sl_we_n SHALL never be low simultaneously; if_ack and dm_ack never high simultaneously.
REQ-014 if_rdata/dm_rdata SHALL hold their value until that port's next read completes.

Reset
REQ-015 Async rst SHALL force state IDLE, sl_oe_n=1, sl_we_n=1, sl_addr=0, sl_wdata=0, sl_be=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, counter=0, last_grant=instruction (data wins the first tie).
REQ-016 rst during SETUP/ACCESS SHALL deassert strobes immediately (no clock needed); the aborted transaction receives no ack.

Structure
REQ-017 State encoding (IDLE/SETUP/ACCESS/DONE) and port IDs SHALL live in shared package bus_pkg.
REQ-018 SHALL be one module; no sub-module needed.

Verification
REQ-019 dm read 0xBFD003F8, WAIT_CYCLES=2, sl_rdata=0x41 -> sl_oe_n low 2 cycles, dm_ack at N+4, dm_rdata=0x00000041.
REQ-020 dm write 0x80400000 data 0xDEADBEEF be=4'b0011 -> sl_we_n low 2 cycles, sl_be=0011, sl_oe_n stays 1, dm_ack once.
REQ-021 if_req and dm_req both held from reset -> grants alternate dm, if, dm, if; each ack exactly once per grant.
REQ-022 if_req pulsed 1 cycle only -> transaction completes, if_ack at N+2+WAIT_CYCLES, if_rdata captured.
REQ-023 rst asserted mid-ACCESS of a write -> sl_we_n high same cycle, no dm_ack, FSM IDLE after release.
